// File: rtl/dmem_responder.sv
// ============================================================================
//  Module      : dmem_responder
//  Description : Fixed-latency data-memory responder with byte-enabled writes
//                and out-of-range error reporting over a register-array RAM.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 200,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic                ack_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                err_o,
    output logic                busy_o
);

    localparam int              c_NB    = DATA_W / 8;
    localparam logic [3:0]      c_LOAD  = 4'(LATENCY - 1);
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [c_NB-1:0]     be_q;

    logic                w_accept;
    logic                w_mem_we;
    logic                w_in_range;

    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    assign w_in_range = ({1'b0, addr_q} < c_DEPTH);

    // ack/rdata/err are registered on the edge that leaves RESP, which puts
    // the ack pulse LATENCY+1 cycles after the accept edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rdata_d  = '0;
        w_accept = 1'b0;
        w_mem_we = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    w_accept = 1'b1;
                    cnt_d    = c_LOAD;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                ack_d   = 1'b1;
                state_d = S_IDLE;
                if (!w_in_range) begin
                    err_d = 1'b1;
                end else if (we_q) begin
                    w_mem_we = 1'b1;
                end else begin
                    rdata_d = mem[addr_q];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            be_q    <= be_i;
        end
    end

    // RAM is never cleared; a reset coinciding with RESP suppresses the write.
    always_ff @(posedge clk) begin
        if (reset && w_mem_we) begin
            for (int b = 0; b < c_NB; b++) begin
                if (be_q[b]) begin
                    mem[addr_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;
    assign busy_o  = (state_q != S_IDLE) || ack_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Directed self-checking bench for dmem_responder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req_i;
    logic        we_i;
    logic [7:0]  addr_i;
    logic [15:0] wdata_i;
    logic [1:0]  be_i;
    logic        ack_o;
    logic [15:0] rdata_o;
    logic        err_o;
    logic        busy_o;

    int n_checks = 0;
    int n_errors = 0;

    dmem_responder #(
        .ADDR_W (8),
        .DATA_W (16),
        .DEPTH  (200),
        .LATENCY(2)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .req_i  (req_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .wdata_i(wdata_i),
        .be_i   (be_i),
        .ack_o  (ack_o),
        .rdata_o(rdata_o),
        .err_o  (err_o),
        .busy_o (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; inputs are sampled at the next posedge (accept edge).
    // lat counts negedges until ack is seen: 4 means ack LATENCY+1=3 edges after accept.
    task automatic txn(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                       input logic [1:0] be, input logic keep,
                       output logic [15:0] rd, output logic er, output int lat);
        logic seen;
        seen    = 1'b0;
        rd      = '0;
        er      = 1'b0;
        lat     = 0;
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        wdata_i = wdata;
        be_i    = be;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (ack_o) begin
                seen = 1'b1;
                rd   = rdata_o;
                er   = err_o;
            end
        end
        if (!seen) check("ack_timeout", 32'(seen), 32'd1);
        if (!keep) req_i = 1'b0;
    endtask

    logic [15:0] rd;
    logic        er;
    int          lat;
    int          acks;

    initial begin
        // Reset held low with a pending request: nothing may happen.
        reset = 1'b0; req_i = 1'b1; we_i = 1'b0; addr_i = 8'd0; wdata_i = '0; be_i = 2'b00;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_ack",   32'(ack_o),   32'd0);
            check("rst_busy",  32'(busy_o),  32'd0);
            check("rst_err",   32'(err_o),   32'd0);
            check("rst_rdata", 32'(rdata_o), 32'd0);
        end
        req_i = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(busy_o), 32'd0);

        // Full write then read back.
        txn(1'b1, 8'd5, 16'hBEEF, 2'b11, 1'b0, rd, er, lat);
        check("wr5_latency", 32'(lat), 32'd4);
        check("wr5_err", 32'(er), 32'd0);
        @(negedge clk);
        check("idle_rdata", 32'(rdata_o), 32'd0);
        check("idle_busy",  32'(busy_o),  32'd0);
        txn(1'b0, 8'd5, 16'h0000, 2'b00, 1'b0, rd, er, lat);
        check("rd5_latency", 32'(lat), 32'd4);
        check("rd5_data", 32'(rd), 32'hBEEF);
        check("rd5_err",  32'(er), 32'd0);

        // Low-byte partial write, then be=0 write must change nothing.
        txn(1'b1, 8'd5, 16'h1234, 2'b01, 1'b0, rd, er, lat);
        txn(1'b0, 8'd5, 16'h0000, 2'b00, 1'b0, rd, er, lat);
        check("rd5_partial", 32'(rd), 32'hBE34);
        txn(1'b1, 8'd5, 16'hFFFF, 2'b00, 1'b0, rd, er, lat);
        check("be0_err", 32'(er), 32'd0);
        txn(1'b0, 8'd5, 16'h0000, 2'b00, 1'b0, rd, er, lat);
        check("rd5_be0", 32'(rd), 32'hBE34);
        txn(1'b1, 8'd5, 16'hAB00, 2'b10, 1'b0, rd, er, lat);
        txn(1'b0, 8'd5, 16'h0000, 2'b00, 1'b0, rd, er, lat);
        check("rd5_hibyte", 32'(rd), 32'hAB34);

        // Range boundary: 199 valid, 200 out of range.
        txn(1'b1, 8'd199, 16'hC0DE, 2'b11, 1'b0, rd, er, lat);
        check("wr199_err", 32'(er), 32'd0);
        txn(1'b0, 8'd200, 16'h0000, 2'b00, 1'b0, rd, er, lat);
        check("rd200_latency", 32'(lat), 32'd4);
        check("rd200_err",   32'(er), 32'd1);
        check("rd200_rdata", 32'(rd), 32'd0);
        txn(1'b1, 8'd200, 16'h5555, 2'b11, 1'b0, rd, er, lat);
        check("wr200_err", 32'(er), 32'd1);
        @(negedge clk);
        check("err_outside_ack", 32'(err_o), 32'd0);
        txn(1'b0, 8'd199, 16'h0000, 2'b00, 1'b0, rd, er, lat);
        check("rd199_err",  32'(er), 32'd0);
        check("rd199_data", 32'(rd), 32'hC0DE);

        // Back-to-back with req held high throughout.
        for (int a = 0; a < 4; a++) begin
            txn(1'b1, 8'(a), 16'h1000 + 16'(a * 16'h0111), 2'b11, 1'b1, rd, er, lat);
            check("b2b_wr_latency", 32'(lat), 32'd4);
        end
        for (int a = 0; a < 4; a++) begin
            txn(1'b0, 8'(a), 16'h0000, 2'b00, (a != 3), rd, er, lat);
            check("b2b_rd_latency", 32'(lat), 32'd4);
            check("b2b_rd_data", 32'(rd), 32'h1000 + 32'(a * 32'h0111));
        end
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack_o) acks++;
        end
        check("b2b_no_extra_ack", 32'(acks), 32'd0);
        check("b2b_idle_busy", 32'(busy_o), 32'd0);

        // Reset during WAIT abandons the write.
        txn(1'b1, 8'd7, 16'hA5A5, 2'b11, 1'b0, rd, er, lat);
        req_i = 1'b1; we_i = 1'b1; addr_i = 8'd7; wdata_i = 16'h00FF; be_i = 2'b11;
        @(negedge clk);
        check("abort_busy", 32'(busy_o), 32'd1);
        reset = 1'b0;
        req_i = 1'b0;
        @(negedge clk);
        check("abort_busy_rst", 32'(busy_o), 32'd0);
        reset = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack_o) acks++;
        end
        check("abort_no_ack", 32'(acks), 32'd0);
        txn(1'b0, 8'd7, 16'h0000, 2'b00, 1'b0, rd, er, lat);
        check("abort_rd7", 32'(rd), 32'hA5A5);
        check("abort_rd7_err", 32'(er), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
